// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Front-end sequencer for the MIPS 32-bit ALU. It accepts a request, decodes
//   ALUOp/funct into the ALU's 4-bit operation code, and holds the operands on
//   the ALU while its one-cycle registered result settles. It then returns the
//   result, the zero flag and an illegal-op flag on a response channel.
//
//   Optional feature macro: ALU_ISSUE_PASSTHRU_EN
//     When this macro is defined, a new request may be accepted on the same
//     edge as a response handshake. This gives one op per 3 cycles.
//     When it is undefined, requests are taken only in IDLE, which gives one
//     op per 4 cycles.
//
//   Ports
//     clk, rst_n                      clock, synchronous active-low reset
//     req_valid/req_ready             request handshake
//     req_aluop[1:0], req_funct[5:0]  opcode fields
//     req_a, req_b [WIDTH]            operands
//     alu_data1, alu_data2 [WIDTH]    registered operands to the ALU
//     alu_operation[3:0]              registered ALU operation code
//     alu_result [WIDTH], alu_zero    ALU outputs (registered / combinational)
//     rsp_valid/rsp_ready             response handshake
//     rsp_result, rsp_zero,
//     rsp_illegal                     captured response
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a request; req_ready=1
//   ISSUE   | operands on ALU; capture combinational zero flag
//   CAPTURE | ALU registered result valid; capture it
//   RESP    | response presented until rsp_ready
module alu_issue_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_aluop,
  input  logic [5:0]       req_funct,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_data1,
  output logic [WIDTH-1:0] alu_data2,
  output logic [3:0]       alu_operation,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_illegal
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_illegal_q, rsp_illegal_d;

  logic [3:0]       dec_op;
  logic             dec_illegal;
  logic             accept;

  // Opcode decode.
  always_comb begin
    dec_op      = 4'b0000;
    dec_illegal = 1'b0;
    unique case (req_aluop)
      2'b00: dec_op = 4'b0010;
      2'b01: dec_op = 4'b0110;
      2'b10: begin
        unique case (req_funct)
          6'b100000: dec_op = 4'b0010;
          6'b100010: dec_op = 4'b0110;
          6'b100100: dec_op = 4'b0000;
          6'b100101: dec_op = 4'b0001;
          6'b101010: dec_op = 4'b0111;
          6'b100111: dec_op = 4'b1100;
          default:   dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

`ifdef ALU_ISSUE_PASSTHRU_EN
  assign req_ready = (state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready);
`else
  assign req_ready = (state_q == S_IDLE);
`endif

  assign accept = req_valid && req_ready;

  always_comb begin
    state_d       = state_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    rsp_result_d  = rsp_result_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_illegal_d = rsp_illegal_q;

    unique case (state_q)
      S_IDLE: ;
      S_ISSUE: begin
        rsp_zero_d = alu_zero;
        state_d    = S_CAPTURE;
      end
      S_CAPTURE: begin
        rsp_result_d  = alu_result;
        rsp_illegal_d = 1'b0;
        state_d       = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // accept can only be high in IDLE or in RESP while the response is being
    // consumed, so it safely overrides the per-state decisions above.
    if (accept) begin
      if (dec_illegal) begin
        rsp_result_d  = '0;
        rsp_zero_d    = 1'b0;
        rsp_illegal_d = 1'b1;
        state_d       = S_RESP;
      end else begin
        alu_a_d  = req_a;
        alu_b_d  = req_b;
        alu_op_d = dec_op;
        state_d  = S_ISSUE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= 4'b0000;
      rsp_result_q  <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      rsp_result_q  <= rsp_result_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  assign alu_data1     = alu_a_q;
  assign alu_data2     = alu_b_q;
  assign alu_operation = alu_op_q;
  assign rsp_valid     = (state_q == S_RESP);
  assign rsp_result    = rsp_result_q;
  assign rsp_zero      = rsp_zero_q;
  assign rsp_illegal   = rsp_illegal_q;

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Front-end sequencer that drives the MIPS 32-bit ALU (registered result, combinational zero flag). Accepts operand/opcode requests over a valid/ready handshake and decodes ALUOp/funct into the ALU's 4-bit operation code. Holds operands stable across the ALU's one-cycle result latency, then returns result, zero flag and an illegal-op flag over a valid/ready response channel. Sits between the datapath control and the ALU instance.

## Interface
- WIDTH, 32, operand/result width; must equal the ALU data width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready at a rising edge
- req_aluop  in  2  00 add, 01 sub, 10 use funct, 11 illegal
- req_funct  in  6  R-type funct field
- req_a, req_b  in  WIDTH  operands
- alu_data1, alu_data2  out  WIDTH  to ALU DataIn1/DataIn2 (registered)
- alu_operation  out  4  to ALU Operation (registered)
- alu_result  in  WIDTH  from ALU Result (valid one cycle after operands/op presented)
- alu_zero  in  1  from ALU Zero (combinational on current operands)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready at a rising edge
- rsp_result  out  WIDTH  captured ALU result
- rsp_zero  out  1  captured zero flag
- rsp_illegal  out  1  opcode could not be decoded; ALU not exercised

## Operation
- Decode: aluop 00 → 0010; 01 → 0110; 10 with funct 100000 → 0010, 100010 → 0110, 100100 → 0000, 100101 → 0001, 101010 → 0111, 100111 → 1100; any other funct, or aluop 11 → illegal.
- FSM states IDLE, ISSUE, CAPTURE, RESP.
- IDLE: req_ready=1. On handshake: legal → register req_a/req_b/decoded op onto alu_* and go ISSUE; illegal → rsp_result=0, rsp_zero=0, rsp_illegal=1, go RESP; alu_* unchanged.
- ISSUE: alu_* held; sample alu_zero into rsp_zero; go CAPTURE.
- CAPTURE: alu_* held; sample alu_result into rsp_result, rsp_illegal=0; go RESP.
- RESP: rsp_valid=1; rsp_* held stable until rsp_ready; on handshake go IDLE.
- req_ready=0 in ISSUE, CAPTURE, RESP (see Configuration). alu_result forwarded unmodified, no width change or sign extension.

## Timing
- Reset (rst_n low at an edge): state IDLE, req_ready=1 from the following cycle, rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_illegal=0, alu_data1=alu_data2=0, alu_operation=0000.
- Reset mid-operation (any state) abandons the transaction; no response is produced.
- Legal request accepted at edge N: alu_* change after N; alu_zero sampled at N+1; alu_result sampled at N+2; rsp_valid high from edge N+2 onward.
- Illegal request accepted at edge N: rsp_valid high from edge N.
- rsp_ready held high: response consumed on its first valid cycle; rsp_ready low: unlimited stall, no output change.
- req_valid asserted while req_ready=0: ignored, no effect.

## Configuration
- ALU_ISSUE_PASSTHRU_EN defined: req_ready = IDLE | (RESP & rsp_ready); a request accepted in the same edge as a response handshake goes straight to ISSUE (or RESP if illegal), giving back-to-back throughput of one op per 3 cycles.
- Not defined: req_ready asserted only in IDLE; one idle cycle between response handshake and next acceptance (one op per 4 cycles minimum).

## Test plan
- Reset: hold rst_n=0 two cycles with req_valid=1 → rsp_valid=0, all alu_*/rsp_* zero; req_ready=1 first cycle after release.
- Add: aluop=00, a=5, b=7, rsp_ready=1 → alu_operation=0010, rsp_valid at N+2 with result=12, zero=0, illegal=0.
- R-type sub equal operands: aluop=10, funct=100010, a=b=0x1234 → op 0110, result=0, zero=1.
- Illegal: aluop=10, funct=000000 → rsp_valid at N, result=0, illegal=1, alu_* unchanged from previous op.
- Backpressure: nor a=0, b=0, rsp_ready=0 for 5 cycles → rsp_result=0xFFFFFFFF stable, req_ready=0 throughout; release → consumed in one cycle.
- Back-to-back with and without ALU_ISSUE_PASSTHRU_EN: two and-ops queued, rsp_ready=1 → acceptances 3 cycles apart (defined) / 4 cycles apart (undefined); reset asserted in CAPTURE → no response, IDLE next cycle.
